// File: rtl/level_stack.sv
// Interrupt-level controller feeding rf_stack: tracks the current level and keeps a LIFO of preempted levels.
// Optional tail-chaining on mret is compiled in with LEVEL_STACK_TAILCHAIN_EN.
module level_stack #(
    parameter int NumLevels = 4,
    localparam int LevelsWidth = $clog2(NumLevels)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   irqValid,
    input  logic [LevelsWidth-1:0] irqLevel,
    input  logic                   mret,
    input  logic                   stall,
    output logic                   irqAck,
    output logic [LevelsWidth-1:0] level,
    output logic                   writeRaEn,
    output logic [LevelsWidth-1:0] depth,
    output logic                   underflow
);

    logic [LevelsWidth-1:0] stack [NumLevels];
    logic [LevelsWidth-1:0] top;
    logic                   push;
    logic                   pop;
    logic                   uflow;
    logic                   tail;

    // Level that a pop would restore; only meaningful while depth != 0.
    assign top = stack[depth - 1'b1];

    always_comb begin
        push  = ~reset & ~stall & irqValid & ~mret & (irqLevel > level);
        pop   = ~reset & ~stall & mret & (depth != '0);
        uflow = ~reset & ~stall & mret & (depth == '0);
        tail  = 1'b0;
`ifdef LEVEL_STACK_TAILCHAIN_EN
        // Compare against the level mret would return to, not the current one.
        tail  = pop & irqValid & (irqLevel > top);
`endif
        irqAck = push | tail;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= '0;
            depth     <= '0;
            writeRaEn <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < NumLevels; i++) begin
                stack[i] <= '0;
            end
        end else begin
            writeRaEn <= push | tail;
            if (push) begin
                stack[depth] <= level;
                depth        <= depth + 1'b1;
                level        <= irqLevel;
            end else if (tail) begin
                level <= irqLevel;
            end else if (pop) begin
                level <= top;
                depth <= depth - 1'b1;
            end
            if (uflow) begin
                underflow <= 1'b1;
            end
        end
    end

    // Levels rise strictly on entry, so a full stack can never be pushed.
    push_within_capacity: assert property (@(posedge clk) disable iff (reset)
        push |-> (depth != LevelsWidth'(NumLevels - 1)));

endmodule

// File: tb/tb_level_stack.sv
// Table-driven bench for level_stack with a queue of expected registered outputs.
module tb_level_stack;

    localparam int NumLevels = 4;
    localparam int LW = $clog2(NumLevels);

    logic          clk = 1'b0;
    logic          reset;
    logic          irqValid;
    logic [LW-1:0] irqLevel;
    logic          mret;
    logic          stall;
    logic          irqAck;
    logic [LW-1:0] level;
    logic          writeRaEn;
    logic [LW-1:0] depth;
    logic          underflow;

    level_stack #(.NumLevels(NumLevels)) dut (
        .clk       (clk),
        .reset     (reset),
        .irqValid  (irqValid),
        .irqLevel  (irqLevel),
        .mret      (mret),
        .stall     (stall),
        .irqAck    (irqAck),
        .level     (level),
        .writeRaEn (writeRaEn),
        .depth     (depth),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          v;
        logic [LW-1:0] il;
        logic          m;
        logic          s;
        logic          ack;
        logic [LW-1:0] lvl;
        logic [LW-1:0] dep;
        logic          wra;
        logic          uf;
    } vec_t;

    typedef struct {
        logic [LW-1:0] lvl;
        logic [LW-1:0] dep;
        logic          wra;
        logic          uf;
        int            idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic rst, input logic v, input int il, input logic m,
                                input logic s, input logic ack, input int lvl, input int dep,
                                input logic wra, input logic uf);
        vec_t r;
        r.rst = rst; r.v = v; r.il = LW'(il); r.m = m; r.s = s;
        r.ack = ack; r.lvl = LW'(lvl); r.dep = LW'(dep); r.wra = wra; r.uf = uf;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational accept, then score registered outputs.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        reset    = v.rst;
        irqValid = v.v;
        irqLevel = v.il;
        mret     = v.m;
        stall    = v.s;
        #1;
        check("irqAck", idx, irqAck, v.ack);
        sbq.push_back('{lvl: v.lvl, dep: v.dep, wra: v.wra, uf: v.uf, idx: idx});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("scoreboard_empty", idx, 1, 0);
        end else begin
            e = sbq.pop_front();
            check("level", e.idx, level, e.lvl);
            check("depth", e.idx, depth, e.dep);
            check("writeRaEn", e.idx, writeRaEn, e.wra);
            check("underflow", e.idx, underflow, e.uf);
        end
    endtask

    initial begin
        reset = 1'b1; irqValid = 1'b0; irqLevel = '0; mret = 1'b0; stall = 1'b0;

        // reset, then idle
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // entry, ignored lower request, nested entry
        tbl.push_back(mk(0, 1, 2, 0, 0, 1, 2, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 3, 2, 1, 0));
        // unwind and underflow
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // stall holds a request; writeRaEn still drops during stall
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 3, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 3, 2, 1, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 3, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 3, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // back-to-back entries to full depth, then unwind
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 1, 2, 2, 1, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 3, 3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // mret coinciding with a request
        tbl.push_back(mk(0, 1, 2, 0, 0, 1, 2, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
`ifdef LEVEL_STACK_TAILCHAIN_EN
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 0));
`else
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 1, 0));
`endif
        // reset mid-sequence discards the stack
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 3, 2, 1, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 1, 2, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // long stall on a pending request, then a stalled mret
        for (int i = 0; i < 4; i++) apply(mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 0), 100 + i);
        apply(mk(0, 1, 2, 0, 0, 1, 2, 1, 1, 0), 104);
        for (int i = 0; i < 2; i++) apply(mk(0, 0, 0, 1, 1, 0, 2, 1, 0, 0), 105 + i);
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 107);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 108);

        check("scoreboard_drained", 200, sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
